mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified word memory (32-bit words, byte-addressed, combinational read, synchronous byte-masked write) between the instruction-fetch port and the load/store data port of the multicycle core. Grants at most one access per cycle, performs byte/halfword lane steering and write-mask generation for SB/SH/SW, and returns LB/LBU/LH/LHU/LW data with registered one-cycle latency. Sits between the core and the memory instance.

Parameters:
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced to win (1..15)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_gnt
if_addr  input  32  fetch byte address
if_gnt  output  1  fetch accepted this cycle (combinational)
if_rvalid  output  1  fetch data valid, one cycle after if_gnt
if_rdata  output  32  fetched word
if_err  output  1  with if_rvalid: if_addr[1:0] was not 00
d_req  input  1  data request, held until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_size  input  2  00 byte, 01 half, 10 word; 11 illegal
d_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
d_wdata  input  32  store data, right-aligned (bits [7:0] for SB)
d_gnt  output  1  data accepted this cycle (combinational)
d_rvalid  output  1  response valid one cycle after d_gnt (loads and stores)
d_rdata  output  32  extended load data; 0 for stores
d_err  output  1  with d_rvalid: misaligned or illegal size, access suppressed
m_we  output  1  memory write enable
m_a  output  32  memory byte address
m_wd  output  32  lane-steered write data
m_wm  output  4  byte write mask, m_wm[0] = byte at a[1:0]=00
m_rd  input  32  memory read word (word-aligned, combinational)

Behaviour:
- Reset: if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_we = 0; if_rdata, d_rdata = 0; m_wm = 0; m_a, m_wd = 0 when idle; starve counter = 0; FSM = IDLE.
- FSM (registered, names which response is presented this cycle): IDLE, RESP_I, RESP_D. Next state = RESP_I if if_gnt, RESP_D if d_gnt, else IDLE. New grant allowed in every state (back-to-back, full throughput).
- Arbitration (combinational from inputs + starve counter): only if_req -> fetch; only d_req -> data; both -> data unless starve counter == STARVE_MAX, then fetch. Never both grants in one cycle.
- Starve counter: increments on d_gnt while if_req=1; clears on if_gnt or when if_req=0; saturates at STARVE_MAX.
- Granted fetch: m_a = if_addr, m_we = 0; m_rd registered into if_rdata; if_rvalid=1 next cycle. Misaligned fetch: if_err=1, if_rdata=0.
- Granted data, alignment: byte any; half needs a[0]=0; word needs a[1:0]=00; d_size=11 always error. On error: m_we=0, m_wm=0, d_rvalid=1 with d_err=1, d_rdata=0 next cycle.
- Store: m_we=1, m_a=d_addr, m_wm: byte = 0001<<a[1:0]; half = 0011<<a[1:0]; word = 1111. m_wd = d_wdata replicated into every byte (SB) or halfword (SH) lane. Write commits at the grant edge; d_rvalid next cycle, d_rdata=0.
- Load: m_we=0; byte lane m_rd[8*a[1:0]+:8], half lane m_rd[16*a[1]+:16], extended per d_unsigned; registered to d_rdata.
- m_* outputs are combinational from the granted request; when nothing granted m_we=0, m_wm=0.
- Response outputs hold their last data value when rvalid=0; rvalid/err are single-cycle pulses.
- Reset asserted mid-operation: pending response dropped, no rvalid in the following cycle, m_we forced 0 during reset.

Optional Feature:
MEM_ARB_RR_EN: when defined, arbitration on simultaneous requests is strict round-robin (last-granted port loses; initial priority data after reset), starve counter and STARVE_MAX unused. Undefined: data-priority with starvation guard as above.

Test Plan:
- Reset then if_req, if_addr=0x8, mem[2]=0x12345678 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0x12345678, FSM RESP_I.
- SB d_addr=0x13, d_wdata=0xAB, mem[4]=0x11223344 -> m_wm=1000, m_wd=0xABABABAB; later LBU 0x13 -> d_rdata=0x000000AB, LB -> 0xFFFFFFAB.
- SH d_addr=0x22, d_wdata=0x8001 -> m_wm=1100; LH 0x22 -> 0xFFFF8001, LHU -> 0x00008001.
- LH d_addr=0x21 -> m_we=0, m_wm=0, next cycle d_rvalid=1, d_err=1, d_rdata=0, memory unchanged; d_size=11 also errors.
- if_req and d_req held high, STARVE_MAX=4 -> grants D,D,D,D,I,D,D,D,D,I; with MEM_ARB_RR_EN -> D,I,D,I.
- Reset asserted the cycle after a load grant -> no d_rvalid, all outputs zero next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and load/store,
// with lane steering, write masks and registered one-cycle responses.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration instead of data priority.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_we,
    output logic [31:0] m_a,
    output logic [31:0] m_wd,
    output logic [3:0]  m_wm,
    input  logic [31:0] m_rd
);

    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

    state_t      state_q, state_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;
    logic        pick_fetch;
    logic        d_misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

`ifdef MEM_ARB_RR_EN
    logic last_i_q, last_i_d;

    always_comb begin
        last_i_d = last_i_q;
        if (if_gnt) begin
            last_i_d = 1'b1;
        end else if (d_gnt) begin
            last_i_d = 1'b0;
        end
    end

    // Resetting as if fetch went last gives data the first contested grant.
    assign pick_fetch = !last_i_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_i_q <= 1'b1;
        end else begin
            last_i_q <= last_i_d;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign pick_fetch = (starve_q == STARVE_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign if_gnt = !reset && if_req && (!d_req || pick_fetch);
    assign d_gnt  = !reset && d_req && (!if_req || !pick_fetch);

    always_comb begin
        case (d_size)
            2'b00:   d_misalign = 1'b0;
            2'b01:   d_misalign = d_addr[0];
            2'b10:   d_misalign = |d_addr[1:0];
            default: d_misalign = 1'b1;
        endcase
    end

    always_comb begin
        case (d_addr[1:0])
            2'b00:   ld_byte = m_rd[7:0];
            2'b01:   ld_byte = m_rd[15:8];
            2'b10:   ld_byte = m_rd[23:16];
            default: ld_byte = m_rd[31:24];
        endcase
        ld_half = d_addr[1] ? m_rd[31:16] : m_rd[15:0];
        case (d_size)
            2'b00:   ld_data = {{24{!d_unsigned && ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{!d_unsigned && ld_half[15]}}, ld_half};
            default: ld_data = m_rd;
        endcase
    end

    always_comb begin
        m_we = 1'b0;
        m_a  = '0;
        m_wd = '0;
        m_wm = '0;
        if (if_gnt) begin
            m_a = if_addr;
        end else if (d_gnt) begin
            m_a = d_addr;
            if (d_we && !d_misalign) begin
                m_we = 1'b1;
                case (d_size)
                    2'b00: begin
                        m_wm = 4'b0001 << d_addr[1:0];
                        m_wd = {4{d_wdata[7:0]}};
                    end
                    2'b01: begin
                        m_wm = 4'b0011 << d_addr[1:0];
                        m_wd = {2{d_wdata[15:0]}};
                    end
                    default: begin
                        m_wm = 4'b1111;
                        m_wd = d_wdata;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d    = IDLE;
        if_rdata_d = if_rdata_q;
        if_err_d   = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_err_d    = 1'b0;
        if (if_gnt) begin
            state_d    = RESP_I;
            if_err_d   = |if_addr[1:0];
            if_rdata_d = if_err_d ? '0 : m_rd;
        end else if (d_gnt) begin
            state_d   = RESP_D;
            d_err_d   = d_misalign;
            d_rdata_d = (d_misalign || d_we) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_rdata_q <= if_rdata_d;
            if_err_q   <= if_err_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    // Masking with reset drops a response whose grant edge preceded the reset cycle.
    assign if_rvalid = (state_q == RESP_I) && !reset;
    assign if_err    = if_err_q && !reset;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = (state_q == RESP_D) && !reset;
    assign d_err     = d_err_q && !reset;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: byte-level reference memory, queued expected
// responses checked by an independent monitor, directed cases then random traffic.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset, init;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        m_we;
    logic [31:0] m_a, m_wd, m_rd;
    logic [3:0]  m_wm;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_we(m_we), .m_a(m_a), .m_wd(m_wd), .m_wm(m_wm), .m_rd(m_rd)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'(32'h9E3779B9 * (i + 1));
    endfunction

    // Memory instance seen by the DUT
    logic [31:0] mem [0:63];
    assign m_rd = mem[m_a[7:2]];
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_wm[b]) mem[m_a[7:2]][8*b +: 8] <= m_wd[8*b +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;
    resp_t iq[$];
    resp_t dq[$];

    // Reference model: byte array plus arbitration history
    logic [7:0]  ref_mem [0:255];
    int          wait_cnt;
    logic        last_fetch;
    logic        g_exp_i, g_exp_d, g_err;
    logic [31:0] g_w, g_v, g_wd;
    logic [3:0]  g_wm;
    int          g_a, g_n;

    always @(negedge clk) begin
        if (init) begin
            for (int i = 0; i < 64; i++) begin
                g_w = init_word(i);
                for (int b = 0; b < 4; b++) ref_mem[4*i + b] = g_w[8*b +: 8];
            end
        end
        if (reset) begin
            wait_cnt   = 0;
            last_fetch = 1'b1;
        end else begin
            if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                g_exp_i = !last_fetch;
`else
                g_exp_i = (wait_cnt == int'(STARVE_MAX));
`endif
                g_exp_d = !g_exp_i;
            end else begin
                g_exp_i = if_req;
                g_exp_d = d_req;
            end
            check("grant", 32'({if_gnt, d_gnt}), 32'({g_exp_i, g_exp_d}));
            if (if_gnt || !if_req) wait_cnt = 0;
            else if (d_gnt && wait_cnt < int'(STARVE_MAX)) wait_cnt++;
            if (if_gnt) last_fetch = 1'b1;
            else if (d_gnt) last_fetch = 1'b0;

            if (if_gnt) begin
                g_a   = int'(if_addr[7:0]);
                g_err = (g_a % 4) != 0;
                g_v   = '0;
                if (!g_err)
                    for (int k = 0; k < 4; k++) g_v |= 32'(ref_mem[g_a + k]) << (8*k);
                iq.push_back('{data: g_v, err: g_err, cyc: cyc});
                check("fetch_m_a", m_a, if_addr);
                check("fetch_m_we", 32'(m_we), 32'd0);
            end else if (d_gnt) begin
                g_a   = int'(d_addr[7:0]);
                g_n   = (d_size == 2'd0) ? 1 : (d_size == 2'd1) ? 2 : 4;
                g_err = (d_size == 2'd3) || ((g_a % g_n) != 0);
                g_v   = '0;
                if (g_err) begin
                    check("err_bus", 32'({m_we, m_wm}), 32'd0);
                end else if (d_we) begin
                    g_wm = '0;
                    for (int k = 0; k < g_n; k++) g_wm[(g_a % 4) + k] = 1'b1;
                    for (int j = 0; j < 4; j++) g_wd[8*j +: 8] = d_wdata[8*(j % g_n) +: 8];
                    check("st_m_we", 32'(m_we), 32'd1);
                    check("st_m_a", m_a, d_addr);
                    check("st_m_wm", 32'(m_wm), 32'(g_wm));
                    check("st_m_wd", m_wd, g_wd);
                    for (int k = 0; k < g_n; k++) ref_mem[g_a + k] = d_wdata[8*k +: 8];
                end else begin
                    for (int k = 0; k < g_n; k++) g_v |= 32'(ref_mem[g_a + k]) << (8*k);
                    if (!d_unsigned && g_n < 4 && g_v[8*g_n - 1])
                        g_v |= ~((32'd1 << (8*g_n)) - 32'd1);
                    check("ld_m_we", 32'(m_we), 32'd0);
                end
                dq.push_back('{data: g_v, err: g_err, cyc: cyc});
            end else begin
                check("idle_bus", 32'({m_we, m_wm}), 32'd0);
            end
        end
    end

    // Response monitor
    logic  mi_exp, md_exp;
    resp_t mi_e, md_e;
    always @(negedge clk) begin
        if (reset) begin
            iq.delete();
            dq.delete();
            check("rst_quiet", 32'({if_rvalid, d_rvalid, if_gnt, d_gnt, m_we}), 32'd0);
        end else begin
            mi_exp = (iq.size() > 0) && (iq[0].cyc < cyc);
            check("if_rvalid", 32'(if_rvalid), 32'(mi_exp));
            if (mi_exp) begin
                mi_e = iq.pop_front();
                if (if_rvalid) begin
                    check("if_rdata", if_rdata, mi_e.data);
                    check("if_err", 32'(if_err), 32'(mi_e.err));
                end
            end
            md_exp = (dq.size() > 0) && (dq[0].cyc < cyc);
            check("d_rvalid", 32'(d_rvalid), 32'(md_exp));
            if (md_exp) begin
                md_e = dq.pop_front();
                if (d_rvalid) begin
                    check("d_rdata", d_rdata, md_e.data);
                    check("d_err", 32'(d_err), 32'(md_e.err));
                end
            end
        end
    end

    task automatic fetch_req(input logic [31:0] addr, output logic [31:0] rdata, output logic err);
        int unsigned n = 0;
        if_req  = 1'b1;
        if_addr = addr;
        @(negedge clk);
        while (!if_gnt && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!if_gnt) check("if_gnt_timeout", 32'(if_gnt), 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        rdata  = if_rdata;
        err    = if_err;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata,
                            output logic [3:0] wm, output logic [31:0] wd,
                            output logic [31:0] rdata, output logic err);
        int unsigned n = 0;
        d_req      = 1'b1;
        d_we       = we;
        d_addr     = addr;
        d_size     = size;
        d_unsigned = uns;
        d_wdata    = wdata;
        @(negedge clk);
        while (!d_gnt && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!d_gnt) check("d_gnt_timeout", 32'(d_gnt), 32'd1);
        wm = m_wm;
        wd = m_wd;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        rdata = d_rdata;
        err   = d_err;
    endtask

    logic [31:0] t_rd, t_wd, f_rd, x_wd, x_rd;
    logic [3:0]  t_wm, x_wm;
    logic        t_err, f_err, x_err;
    logic [1:0]  f_off;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        init = 1'b1; reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = '0; d_unsigned = 1'b0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1 init = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_we, m_wm}), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_m_a", m_a, 32'd0);
        check("rst_m_wd", m_wd, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        data_req(1'b1, 32'h08, 2'd2, 1'b0, 32'h12345678, t_wm, t_wd, t_rd, t_err);
        data_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344, t_wm, t_wd, t_rd, t_err);
        data_req(1'b1, 32'h20, 2'd2, 1'b0, 32'h55667788, t_wm, t_wd, t_rd, t_err);
        fetch_req(32'h08, t_rd, t_err);
        check("fetch_word", t_rd, 32'h12345678);
        check("fetch_ok", 32'(t_err), 32'd0);
        fetch_req(32'h0A, t_rd, t_err);
        check("fetch_mis_rdata", t_rd, 32'd0);
        check("fetch_mis_err", 32'(t_err), 32'd1);

        data_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000AB, t_wm, t_wd, t_rd, t_err);
        check("sb_wm", 32'(t_wm), 32'b1000);
        check("sb_wd", t_wd, 32'hABABABAB);
        check("sb_rdata", t_rd, 32'd0);
        data_req(1'b0, 32'h13, 2'd0, 1'b1, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("lbu", t_rd, 32'h000000AB);
        data_req(1'b0, 32'h13, 2'd0, 1'b0, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("lb", t_rd, 32'hFFFFFFAB);
        data_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("lw_after_sb", t_rd, 32'hAB223344);

        data_req(1'b1, 32'h22, 2'd1, 1'b0, 32'h00008001, t_wm, t_wd, t_rd, t_err);
        check("sh_wm", 32'(t_wm), 32'b1100);
        check("sh_wd", t_wd, 32'h80018001);
        data_req(1'b0, 32'h22, 2'd1, 1'b0, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("lh", t_rd, 32'hFFFF8001);
        data_req(1'b0, 32'h22, 2'd1, 1'b1, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("lhu", t_rd, 32'h00008001);

        data_req(1'b0, 32'h21, 2'd1, 1'b0, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("lh_mis_err", 32'(t_err), 32'd1);
        check("lh_mis_rdata", t_rd, 32'd0);
        data_req(1'b0, 32'h20, 2'd3, 1'b0, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("size3_err", 32'(t_err), 32'd1);
        data_req(1'b1, 32'h21, 2'd2, 1'b0, 32'hDEADBEEF, t_wm, t_wd, t_rd, t_err);
        check("sw_mis_wm", 32'(t_wm), 32'd0);
        check("sw_mis_err", 32'(t_err), 32'd1);
        data_req(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, t_wm, t_wd, t_rd, t_err);
        check("mem_unchanged", t_rd, 32'h80017788);

        // Both ports held: contested grant pattern from reset
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h08;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2; d_unsigned = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            check("arb_seq", 32'(if_gnt), 32'((k % 2) == 1));
`else
            check("arb_seq", 32'(if_gnt), 32'((k % (int'(STARVE_MAX) + 1)) == int'(STARVE_MAX)));
`endif
            @(posedge clk);
            #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the response cycle of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_size = 2'd2;
        @(negedge clk);
        check("rst_mid_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk);
        #1 d_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst_mid_rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_ctrl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_we, m_wm}), 32'd0);
        check("rst_mid_d_rdata", d_rdata, 32'd0);
        check("rst_mid_if_rdata", if_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_no_late", 32'(d_rvalid), 32'd0);
        @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    f_off = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                    fetch_req({24'd0, 6'($urandom_range(0, 63)), f_off}, f_rd, f_err);
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    data_req(1'($urandom_range(0, 1)),
                             {24'd0, 8'($urandom_range(0, 255))},
                             ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                             1'($urandom_range(0, 1)), $urandom(),
                             x_wm, x_wd, x_rd, x_err);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
